// File: rtl/pll_v1_pkg.sv
// Shared constants for the pll_v1 clock-IP stand-in.
package pll_v1_pkg;

    localparam int PLL_OUT_DIV_DEF     = 4;
    localparam int PLL_DUTY_HIGH_DEF   = 2;
    localparam int PLL_PHASE_DEF       = 0;
    localparam int PLL_LOCK_CYCLES_DEF = 1024;
    localparam int PLL_CLKIN_MHZ       = 50;

endpackage

// File: rtl/pll_v1_lock_timer.sv
// Saturating settle counter; pll_lock rises on the LOCK_CYCLES-th edge out of reset.
module pll_v1_lock_timer
    import pll_v1_pkg::*;
#(
    parameter int LOCK_CYCLES = PLL_LOCK_CYCLES_DEF
) (
    input  logic clkin1,
    input  logic rst_n,
    output logic pll_lock
);

    localparam int CW = $clog2(LOCK_CYCLES + 1);
    localparam logic [CW-1:0] LOCK_TERM = CW'(LOCK_CYCLES - 1);

    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_q, lock_d;

    // Lock is set on the same edge the count lands on LOCK_CYCLES, then both hold.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (!lock_q) begin
            lock_cnt_d = lock_cnt_q + CW'(1);
            if (lock_cnt_q == LOCK_TERM) begin
                lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clkin1) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign pll_lock = lock_q;

endmodule

// File: rtl/pll_v1_gen.sv
// Digital stand-in for the pll_v1 clock IP: lock after a settle interval, then a
// registered divided clock with programmable ratio, duty and phase.
module pll_v1_gen
    import pll_v1_pkg::*;
#(
    parameter int OUT_DIV     = PLL_OUT_DIV_DEF,
    parameter int DUTY_HIGH   = PLL_DUTY_HIGH_DEF,
    parameter int PHASE       = PLL_PHASE_DEF,
    parameter int LOCK_CYCLES = PLL_LOCK_CYCLES_DEF
) (
    input  logic clkin1,
    input  logic rst_n,
    input  logic clkout0_gate,
    output logic clkout0,
    output logic pll_lock
);

    if (OUT_DIV < 2) begin : g_bad_div
        $error("pll_v1_gen: OUT_DIV must be at least 2");
    end
    if (DUTY_HIGH < 1 || DUTY_HIGH > OUT_DIV - 1) begin : g_bad_duty
        $error("pll_v1_gen: DUTY_HIGH must be in 1..OUT_DIV-1");
    end
    if (PHASE < 0 || PHASE > OUT_DIV - 1) begin : g_bad_phase
        $error("pll_v1_gen: PHASE must be in 0..OUT_DIV-1");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("pll_v1_gen: LOCK_CYCLES must be at least 1");
    end

    localparam int DW = $clog2(OUT_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(OUT_DIV - 1);
    localparam logic [DW-1:0] DUTY_CNT  = DW'(DUTY_HIGH);
    localparam logic [DW-1:0] PHASE_CNT = DW'(PHASE);

    logic          lock;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          clkout0_q, clkout0_d;

    pll_v1_lock_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_timer (
        .clkin1   (clkin1),
        .rst_n    (rst_n),
        .pll_lock (lock)
    );

    // The gate only masks the output; the count keeps running so ungating stays in phase.
    always_comb begin
        div_cnt_d = PHASE_CNT;
        clkout0_d = 1'b0;
        if (lock) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
            clkout0_d = (div_cnt_q < DUTY_CNT) && !clkout0_gate;
        end
    end

    always_ff @(posedge clkin1) begin
        if (!rst_n) begin
            div_cnt_q <= PHASE_CNT;
            clkout0_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            clkout0_q <= clkout0_d;
        end
    end

    assign clkout0  = clkout0_q;
    assign pll_lock = lock;

endmodule

// File: tb/tb_pll_v1_gen.sv
// Bench for pll_v1_gen: three parameterisations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pll_v1_gen;
    import pll_v1_pkg::*;

    localparam realtime HALF_NS = 1000.0 / (2.0 * PLL_CLKIN_MHZ);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic gate = 1'b0;
    logic [2:0] lock_o;
    logic [2:0] clk_o;

    always #(HALF_NS) clk = ~clk;

    // 0: defaults, 1: div 5 / duty 1 / phase 3 / lock 16, 2: lock 1 / div 2 / duty 1
    pll_v1_gen u_dut_a (
        .clkin1(clk), .rst_n(rst_n), .clkout0_gate(gate),
        .clkout0(clk_o[0]), .pll_lock(lock_o[0]));

    pll_v1_gen #(.OUT_DIV(5), .DUTY_HIGH(1), .PHASE(3), .LOCK_CYCLES(16)) u_dut_b (
        .clkin1(clk), .rst_n(rst_n), .clkout0_gate(gate),
        .clkout0(clk_o[1]), .pll_lock(lock_o[1]));

    pll_v1_gen #(.OUT_DIV(2), .DUTY_HIGH(1), .PHASE(0), .LOCK_CYCLES(1)) u_dut_c (
        .clkin1(clk), .rst_n(rst_n), .clkout0_gate(gate),
        .clkout0(clk_o[2]), .pll_lock(lock_o[2]));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: edges since reset release decide lock; the output value at
    // edge k after lock is ((PHASE + k) mod DIV) < DUTY, masked by the gate.
    int  m_lock[3] = '{PLL_LOCK_CYCLES_DEF, 16, 1};
    int  m_div[3]  = '{PLL_OUT_DIV_DEF, 5, 2};
    int  m_duty[3] = '{PLL_DUTY_HIGH_DEF, 1, 1};
    int  m_phase[3] = '{PLL_PHASE_DEF, 3, 0};
    int  m_rel[3]  = '{0, 0, 0};
    logic m_clk[3] = '{1'b0, 1'b0, 1'b0};
    logic sb_on = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_rel[i] <= 0;
                m_clk[i] <= 1'b0;
            end else begin
                m_rel[i] <= m_rel[i] + 1;
                m_clk[i] <= (m_rel[i] >= m_lock[i]) &&
                            (((m_phase[i] + m_rel[i] - m_lock[i]) % m_div[i]) < m_duty[i]) &&
                            !gate;
            end
        end
        sb_on <= 1'b1;
    end

    always @(negedge clk) begin
        if (sb_on) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("sb_lock[%0d]", i), lock_o[i], m_rel[i] >= m_lock[i]);
                chk($sformatf("sb_clkout[%0d]", i), clk_o[i], m_clk[i]);
            end
        end
    end

    realtime rise_t[2];
    int      n_rise = 0;
    always @(posedge clk_o[0]) begin
        if (n_rise < 2) begin
            rise_t[n_rise] = $realtime;
            n_rise++;
        end
    end

    typedef struct {
        logic gate;
        logic exp_clk;
    } vec_t;

    vec_t tbl[20];
    logic seq_b[8];

    initial begin
        int n;
        int relock;
        int rises;
        int falls;
        logic prev;

        // Defaults (div 4, duty 2, phase 0): 1,1,0,0 repeating, gate held for rows 8..14.
        tbl[0]  = '{1'b0, 1'b1}; tbl[1]  = '{1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0}; tbl[3]  = '{1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1}; tbl[5]  = '{1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0}; tbl[7]  = '{1'b0, 1'b0};
        for (int i = 8; i < 15; i++) tbl[i] = '{1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0}; tbl[16] = '{1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b1}; tbl[18] = '{1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0};
        seq_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        gate  = 1'b0;
        repeat (10) step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_lock[%0d]", i), lock_o[i], 1'b0);
            chk($sformatf("reset_clkout[%0d]", i), clk_o[i], 1'b0);
        end

        rst_n = 1'b1;
        n = 0;
        while (n < 2000) begin
            step();
            n++;
            if (n == 1) chk("c_lock_first_edge", lock_o[2], 1'b1);
            if (n == 2) chk("c_clkout_edge2", clk_o[2], 1'b1);
            if (n == 3) chk("c_clkout_edge3", clk_o[2], 1'b0);
            if (n >= 17 && n <= 24) chk($sformatf("b_seq[%0d]", n - 17), clk_o[1], seq_b[n-17]);
            if (lock_o[0]) break;
        end
        chk_int("a_lock_latency", n, 1024);

        for (int i = 0; i < 20; i++) begin
            gate = tbl[i].gate;
            step();
            chk($sformatf("a_tbl[%0d]", i), clk_o[0], tbl[i].exp_clk);
        end
        gate = 1'b0;
        chk_int("a_rise_count", n_rise, 2);
        if (n_rise >= 2)
            chk_int("a_period_ps", longint'((rise_t[1] - rise_t[0]) * 1000.0), 80000);

        for (int i = 0; i < 480; i++) begin
            gate = logic'($urandom_range(0, 1));
            step();
        end

        // One-cycle reset pulse 500 edges after lock.
        gate  = 1'b0;
        rst_n = 1'b0;
        step();
        chk("pulse_lock_a", lock_o[0], 1'b0);
        chk("pulse_clkout_a", clk_o[0], 1'b0);
        chk("pulse_lock_c", lock_o[2], 1'b0);
        rst_n = 1'b1;

        relock = -1;
        rises  = 0;
        falls  = 0;
        prev   = lock_o[0];
        for (int j = 1; j <= 4096; j++) begin
            gate = logic'($urandom_range(0, 1));
            step();
            if (lock_o[0] && !prev) begin
                rises++;
                if (relock < 0) relock = j;
            end
            if (!lock_o[0] && prev) falls++;
            prev = lock_o[0];
        end
        chk_int("a_relock_edge", relock, 1024);
        chk_int("a_lock_rises", rises, 1);
        chk_int("a_lock_falls", falls, 0);

        // Reset arriving on the terminal lock edge must win.
        gate  = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (1023) step();
        chk("a_pre_terminal", lock_o[0], 1'b0);
        rst_n = 1'b0;
        step();
        chk("a_reset_wins", lock_o[0], 1'b0);
        chk("c_reset_wins", lock_o[2], 1'b0);
        rst_n = 1'b1;
        step();
        chk("c_relock_first_edge", lock_o[2], 1'b1);
        chk("a_still_unlocked", lock_o[0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_v1_gen.md
# pll_v1_gen

Synthesizable digital stand-in for the `pll_v1` clock IP, used where the vendor PLL primitive is unavailable. It runs on the 50 MHz board clock `clkin1`. It asserts `pll_lock` after a fixed settle interval, then emits `clkout0` as a registered divided clock with programmable divide ratio, duty and phase. It sits at the top of the clocking tree and feeds downstream logic that waits on `pll_lock` before leaving reset.

## Interface
Parameters:
- `OUT_DIV`, default 4: divide ratio of `clkout0` relative to `clkin1`; must be at least 2.
- `DUTY_HIGH`, default 2: `clkin1` cycles per period that `clkout0` is high; legal range 1 to `OUT_DIV-1`.
- `PHASE`, default 0: initial divider count, giving a phase offset in input cycles; legal range 0 to `OUT_DIV-1`.
- `LOCK_CYCLES`, default 1024: settle interval before lock, counted in `clkin1` cycles with reset released; must be at least 1.

Ports:
- `clkin1`, in, 1 bit: the only clock; all logic runs on its rising edge.
- `rst_n`, in, 1 bit: one clock; reset is synchronous and active-low.
- `clkout0_gate`, in, 1 bit: when 1, forces `clkout0` low; the divider keeps counting.
- `clkout0`, out, 1 bit: registered divided clock.
- `pll_lock`, out, 1 bit: lock indicator.

## Operation
- Illegal parameter values cause an elaboration-time error.
- **Lock timer**
  - The counter width is `$clog2(LOCK_CYCLES+1)`.
  - While `rst_n` is 0 at a rising edge, the counter, `pll_lock`, the divider count (set to `PHASE`) and `clkout0` all clear.
  - While unlocked, the counter increments once per edge at which `rst_n` is 1.
  - `pll_lock` becomes 1 when the counter reaches `LOCK_CYCLES`; the counter then saturates.
- **Lock stability**
  - Once set, `pll_lock` stays 1 until `rst_n` is sampled low.
  - It never glitches and never toggles more than once per reset release.
- **Divider**
  - Counter width is `$clog2(OUT_DIV)`.
  - While `pll_lock` is 0, `div_cnt` holds `PHASE` and `clkout0` is 0.
  - While `pll_lock` is 1, on each edge:
    - `div_cnt` wraps: it becomes 0 if it equals `OUT_DIV-1`, otherwise it increments by 1.
    - `clkout0` is set to (`div_cnt < DUTY_HIGH`) AND NOT `clkout0_gate`, using the pre-update `div_cnt`.
- **Gating**
  - `clkout0_gate` is sampled each edge; it affects `clkout0` only and does not touch the divider count.
  - On ungating, `clkout0` resumes in phase with the count.
- **Reset mid-operation:** a synchronous `rst_n` low clears everything on the same edge, and the lock interval restarts from zero.

## Timing
- Reset values: `pll_lock`=0, `clkout0`=0.
- Lock latency: `pll_lock` rises on the `LOCK_CYCLES`-th rising edge at which `rst_n` is sampled 1.
- First `clkout0` update: the first edge after `pll_lock` is 1, i.e. `LOCK_CYCLES+1` edges after reset release.
- `clkout0` period is `OUT_DIV` input cycles, with `DUTY_HIGH` cycles high.
- With `PHASE`=p, the first high occurs immediately if p < `DUTY_HIGH`; otherwise it occurs after `OUT_DIV`−p edges.
- `clkout0_gate` latency: 1 cycle.
- Simultaneous `rst_n` low and terminal lock count: reset wins.

## Structure
- Package `pll_v1_pkg` holds:
  - the default constants `PLL_OUT_DIV_DEF`, `PLL_DUTY_HIGH_DEF`, `PLL_PHASE_DEF`, `PLL_LOCK_CYCLES_DEF`;
  - the reference input frequency `PLL_CLKIN_MHZ` = 50.
- Sub-module `pll_v1_lock_timer` contains the saturating lock counter plus the `pll_lock` register.
- The divider and output register live in the top level.

## Test plan
- Defaults, with `rst_n` low for 10 cycles then high:
  - `pll_lock`=0 for exactly 1023 edges and becomes 1 on edge 1024;
  - over the following 4096 cycles, `pll_lock` has exactly one rising edge and no falls.
- Lock established, `OUT_DIV`=4, `DUTY_HIGH`=2, `PHASE`=0: `clkout0` sequence is 1,1,0,0 repeating; measured period is 80 ns at 50 MHz.
- `OUT_DIV`=5, `DUTY_HIGH`=1, `PHASE`=3: after lock, `clkout0` reads 0,0,1,0,0,0,0,1 and continues with one high every 5 cycles.
- `clkout0_gate`=1 for 7 cycles mid-run: `clkout0` reads 0 throughout; after release it matches an ungated reference divider exactly.
- `rst_n` pulsed low for 1 cycle at 500 cycles after lock:
  - `pll_lock` and `clkout0` are 0 on that edge;
  - relock occurs 1024 edges after release.
- `LOCK_CYCLES`=1, `OUT_DIV`=2, `DUTY_HIGH`=1:
  - `pll_lock`=1 on the first edge after reset release;
  - `clkout0` toggles every cycle from the next edge onward.
